bcd_updown_counter: RTL

Parametrised multi-digit BCD counter with up/down counting, parallel load, wrap or saturate at the count limits, and per-digit enable outputs for chaining and display logic. It is the general-purpose successor to the fixed 4-digit up-only decade counter. It sits next to timers, frequency meters and display drivers that consume packed BCD directly.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_cell.sv | 52 +++++
 rtl/bcd_updown_counter.sv | 90 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MAX     : largest legal digit value (9)
//   BCD_MIN     : smallest legal digit value (0)
//   bcd_valid() : true when a nibble is a legal BCD digit
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with load, step (up or down), hold and reset.
// Ports:
//   clk      : clock, state changes on rising edge
//   reset    : synchronous active-high, clears the digit
//   step     : advance the digit one position in direction 'up'
//   up       : 1 = count up, 0 = count down
//   load     : load load_val (illegal nibbles become 0)
//   load_val : digit value to load
//   value    : registered digit value, always 0..9
//   is_term  : combinational, digit sits at the terminal value for 'up'
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       is_term
);

  bcd_digit_t digit_reg;
  bcd_digit_t digit_next;

  always_comb begin
    digit_next = digit_reg;
    if (load) begin
      // Non-BCD nibbles are replaced so the register never leaves 0..9.
      digit_next = bcd_valid(load_val) ? load_val : BCD_MIN;
    end else if (step) begin
      if (up) begin
        digit_next = (digit_reg == BCD_MAX) ? BCD_MIN : digit_reg + 4'd1;
      end else begin
        digit_next = (digit_reg == BCD_MIN) ? BCD_MAX : digit_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_reg <= BCD_MIN;
    end else begin
      digit_reg <= digit_next;
    end
  end

  assign value   = digit_reg;
  assign is_term = up ? (digit_reg == BCD_MAX) : (digit_reg == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with parallel load and
// wrap-or-saturate behaviour at the count limits.
// Parameters:
//   DIGITS : number of BCD digits (>= 1)
//   WRAP   : 1 = wrap at the limits, 0 = saturate
// Ports:
//   clk      : clock
//   reset    : synchronous active-high, clears q and load_err
//   en       : count enable
//   up       : direction, 1 = up, 0 = down
//   load     : parallel load strobe (beats en)
//   load_val : packed BCD load value, digit 0 in [3:0]
//   q        : registered packed BCD count
//   ena      : combinational per-digit step enables for digits 1..DIGITS-1
//              (single bit tied to 0 when DIGITS = 1)
//   tc       : combinational terminal count
//   load_err : registered, one-cycle pulse after a load with a bad nibble
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   en,
  input  logic                                   up,
  input  logic                                   load,
  input  logic [4*DIGITS-1:0]                    load_val,
  output logic [4*DIGITS-1:0]                    q,
  output logic [(DIGITS > 1 ? DIGITS-1 : 1):1]   ena,
  output logic                                   tc,
  output logic                                   load_err
);

  localparam logic SATURATE = (WRAP == 0);

  // below_term[i] : digits 0..i-1 all hold the terminal value.
  logic [DIGITS:0]   below_term;
  logic [DIGITS-1:0] is_term;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad_nibble;
  logic              count_active;
  logic              hold;
  logic              load_err_reg;
  logic              load_err_next;

  // Counting is only considered when neither reset nor load owns the cycle.
  assign count_active = en & ~reset & ~load;
  assign below_term[0] = 1'b1;
  assign tc   = count_active & below_term[DIGITS];
  // In saturate mode the whole count freezes at its limit.
  assign hold = SATURATE & tc;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign below_term[gi+1] = below_term[gi] & is_term[gi];
    assign step[gi]         = count_active & below_term[gi] & ~hold;
    assign bad_nibble[gi]   = ~bcd_valid(load_val[4*gi +: 4]);

    bcd_digit_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .step     (step[gi]),
      .up       (up),
      .load     (load),
      .load_val (load_val[4*gi +: 4]),
      .value    (q[4*gi +: 4]),
      .is_term  (is_term[gi])
    );
  end

  if (DIGITS > 1) begin : g_ena
    assign ena = count_active ? below_term[DIGITS-1:1] : '0;
  end else begin : g_ena_none
    assign ena = 1'b0;
  end

  assign load_err_next = load & (|bad_nibble);

  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_reg <= 1'b0;
    end else begin
      load_err_reg <= load_err_next;
    end
  end

  assign load_err = load_err_reg;

endmodule
